oddr71_tx_serializer: RTL



---
 rtl/oddr71_tx_serializer_if.sv | 21 ++
 rtl/oddr71_tx_serializer.sv | 53 +++++
 2 files changed

// File: rtl/oddr71_tx_serializer_if.sv
// oddr71_tx_serializer_if: word handshake, training request and serial outputs of the serializer
interface oddr71_tx_serializer_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] D;
  logic DVALID;
  logic DREADY;
  logic TRAIN;
  logic DO;
  logic FRAME;
  logic [1:0] MODE;
  logic UNDERRUN;
  modport master (
    output D, DVALID, TRAIN,
    input DREADY, DO, FRAME, MODE, UNDERRUN
  );
  modport slave (
    input D, DVALID, TRAIN,
    output DREADY, DO, FRAME, MODE, UNDERRUN
  );
endinterface

// File: rtl/oddr71_tx_serializer.sv
// oddr71_tx_serializer: word-to-bit serializer, bit 0 first, with training and idle word insertion
module oddr71_tx_serializer #(
  parameter int WIDTH = 7,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = 7'b1100011,
  parameter logic IDLE_BIT = 1'b0
) (
  input logic ECLK,
  input logic RST,
  oddr71_tx_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_DATA = 2'd1;
  localparam logic [1:0] MODE_TRAIN = 2'd2;
  logic [CW-1:0] cnt;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shifted;
  logic [1:0] mode_next;
  logic boundary;
  always_comb begin
    boundary = cnt == LAST;
    word = bus.TRAIN ? TRAIN_PATTERN : bus.DVALID ? bus.D : {WIDTH{IDLE_BIT}};
    mode_next = bus.TRAIN ? MODE_TRAIN : bus.DVALID ? MODE_DATA : MODE_IDLE;
    shifted = {IDLE_BIT, sr};
  end
  // training holds off the handshake so a pending data word is never consumed
  assign bus.DREADY = boundary & ~bus.TRAIN & ~RST;
  always_ff @(posedge ECLK) begin
    if (RST) begin
      cnt <= LAST;
      sr <= {(WIDTH - 1){IDLE_BIT}};
      bus.DO <= IDLE_BIT;
      bus.FRAME <= 1'b0;
      bus.MODE <= MODE_IDLE;
      bus.UNDERRUN <= 1'b0;
    end else if (boundary) begin
      cnt <= '0;
      sr <= word[WIDTH-1:1];
      bus.DO <= word[0];
      bus.FRAME <= 1'b1;
      bus.MODE <= mode_next;
      bus.UNDERRUN <= mode_next == MODE_IDLE && bus.MODE == MODE_DATA;
    end else begin
      cnt <= cnt + CW'(1);
      sr <= shifted[WIDTH-1:1];
      bus.DO <= sr[0];
      bus.FRAME <= 1'b0;
      bus.UNDERRUN <= 1'b0;
    end
  end
endmodule
